fence_ctrl: RTL and testbench
=============================

# fence_ctrl

Sequential fence controller for the kakacpu core. It sits between decode and the LSU/instruction cache and executes FENCE, FENCE.TSO and FENCE.I. It stalls younger instructions, drains outstanding memory operations, invalidates the I-cache and requests a refetch for FENCE.I, and flags illegal funct3 encodings. It tracks in-flight memory operations itself, and the FENCE.I support can be removed by parameter.

## Interface
Parameters:
- OUTSTANDING_W, default 4: width of the in-flight memory-operation counter. The counter's maximum value is 2^OUTSTANDING_W-1.
- HAS_ZIFENCEI, default 1: 1 implements FENCE.I; 0 treats funct3=001 as illegal.

Ports (name, direction, width, meaning):
- clk  in  1  core clock, rising edge
- rst  in  1  reset; one clock; asynchronous, active-low (rst=0 resets)
- req_valid  in  1  decode presents a MISC-MEM instruction
- req_ready  out  1  controller accepts the request
- funct3  in  3  instruction funct3
- pred  in  4  predecessor set {I,O,R,W}
- succ  in  4  successor set {I,O,R,W}
- mem_issue  in  1  LSU accepted one memory op this cycle
- mem_done  in  1  LSU retired one memory op this cycle
- outstanding  out  OUTSTANDING_W  current in-flight count
- stall  out  1  hold all younger instructions
- icache_inval_req  out  1  I-cache invalidate request, level
- icache_inval_ack  in  1  invalidate complete, single-cycle pulse
- flush  out  1  one-cycle pulse: refetch after FENCE.I
- done  out  1  one-cycle pulse: fence completed
- illegal  out  1  one-cycle pulse: illegal funct3 accepted

## Operation
Counter:
- mem_issue only: +1. mem_done only: -1. Both asserted: unchanged.
- The counter saturates at the maximum; an increment at max is dropped.
- A decrement at 0 is ignored.
- The counter updates in every state.

FSM states: IDLE, DRAIN, INVAL, DONE.
- IDLE:
  - req_ready=1, stall=0.
  - Accept occurs on req_valid at the rising edge.
  - funct3=000, pred==0 or succ==0: no-op fence, go to DONE.
  - funct3=000 otherwise: go to DRAIN. FENCE.TSO (fm ignored) is handled as a full FENCE.
  - funct3=001 with HAS_ZIFENCEI=1: go to DRAIN with the latched flag is_fi=1.
  - Any other funct3, or 001 with HAS_ZIFENCEI=0: register illegal=1 for the next cycle and stay in IDLE.
- DRAIN:
  - stall=1.
  - When outstanding==0 in this cycle: go to INVAL if is_fi, otherwise go to DONE.
  - mem_issue arriving during DRAIN is still counted and extends the drain.
- INVAL:
  - stall=1, icache_inval_req=1.
  - On icache_inval_ack, go to DONE. An ack in any other state is ignored.
- DONE:
  - stall=1, done=1; flush=1 if is_fi.
  - Go to IDLE next cycle and clear is_fi.
- req_ready=0 outside IDLE.

## Timing
- Reset values: state=IDLE, outstanding=0, is_fi=0. Outputs: req_ready=1, stall=0, icache_inval_req=0, flush=0, done=0, illegal=0.
- Accepting a request at edge T takes effect from cycle T+1.
- No-op fence: done in T+1; ready again in T+2.
- FENCE with outstanding==0: DRAIN in T+1, done in T+2.
- FENCE with outstanding=N and one mem_done per cycle: DRAIN lasts N+1 cycles, then done.
- FENCE.I: the request rises on the cycle after drain completes. DONE (done and flush) follows the cycle after ack.
- Illegal funct3: illegal high in T+1 only. A new request can be accepted at the T+1 edge.
- Reset mid-operation: all state and outputs return to reset values immediately. An in-progress invalidate request drops; the I-cache must tolerate this.
- All outputs are registered-state decodes; none depends combinationally on inputs.

## Test plan
- Reset with rst=0 -> all outputs at reset values and outstanding=0. Release rst; a FENCE with pred=succ=0011 and no traffic -> done high exactly 2 cycles after accept, stall high for cycles 1-2.
- 3 mem_issue pulses, then a FENCE (pred=succ=1111), then mem_done on 3 later cycles -> stall held until outstanding==0; done 1 cycle after the count reaches 0; flush stays 0.
- FENCE.I with 1 outstanding op and ack delayed 5 cycles -> icache_inval_req rises after drain and stays level until the ack; done and flush pulse together for one cycle.
- funct3 swept 010..111 -> illegal pulses once per accept; no stall, done or flush. Repeat for funct3=001 with HAS_ZIFENCEI=0 -> illegal.
- Counter edges: OUTSTANDING_W=2 with 4 issues -> saturates at 3. mem_issue and mem_done in the same cycle -> count unchanged. mem_done at 0 -> stays 0. Issue during DRAIN extends the stall.
- rst asserted during INVAL -> req and stall drop immediately. After release, a new FENCE completes normally with no stray ack effect.

Source files
------------

// File: rtl/fence_ctrl.sv
// fence_ctrl: FENCE / FENCE.TSO / FENCE.I sequencer for kakacpu.
// Drains in-flight memory ops, invalidates the I-cache and requests refetch.
module fence_ctrl #(
    parameter int OUTSTANDING_W = 4,
    parameter int HAS_ZIFENCEI  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               funct3,
    input  logic [3:0]               pred,
    input  logic [3:0]               succ,
    input  logic                     mem_issue,
    input  logic                     mem_done,
    output logic [OUTSTANDING_W-1:0] outstanding,
    output logic                     stall,
    output logic                     icache_inval_req,
    input  logic                     icache_inval_ack,
    output logic                     flush,
    output logic                     done,
    output logic                     illegal
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_INVAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [OUTSTANDING_W-1:0] CNT_MAX  = '1;
    localparam logic [OUTSTANDING_W-1:0] CNT_ZERO = '0;
    localparam logic [OUTSTANDING_W-1:0] CNT_ONE  = CNT_ZERO + 1'b1;
    localparam bit                       FI_EN    = (HAS_ZIFENCEI != 0);

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic                     is_fi;
    logic                     is_fi_nxt;
    logic                     illegal_q;
    logic                     illegal_nxt;
    logic [OUTSTANDING_W-1:0] cnt;

    logic is_fence;
    logic is_fencei;
    logic is_noop;
    logic cnt_zero;
    logic cnt_inc;
    logic cnt_dec;

    assign is_fence  = (funct3 == 3'b000);
    assign is_fencei = (funct3 == 3'b001) && FI_EN;
    assign is_noop   = (pred == 4'b0000) || (succ == 4'b0000);
    assign cnt_zero  = (cnt == CNT_ZERO);
    assign cnt_inc   = mem_issue && !mem_done && (cnt != CNT_MAX);
    assign cnt_dec   = mem_done && !mem_issue && !cnt_zero;

    // In-flight memory-op counter; saturating up, floored at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= CNT_ZERO;
        end else if (cnt_inc) begin
            cnt <= cnt + CNT_ONE;
        end else if (cnt_dec) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // Next-state decode for the fence sequence
    always_comb begin
        state_nxt   = state;
        is_fi_nxt   = is_fi;
        illegal_nxt = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    unique case (1'b1)
                        is_fence: begin
                            state_nxt = is_noop ? S_DONE : S_DRAIN;
                            is_fi_nxt = 1'b0;
                        end
                        is_fencei: begin
                            state_nxt = S_DRAIN;
                            is_fi_nxt = 1'b1;
                        end
                        default: begin
                            illegal_nxt = 1'b1;
                        end
                    endcase
                end
            end
            S_DRAIN: begin
                if (cnt_zero) begin
                    state_nxt = is_fi ? S_INVAL : S_DONE;
                end
            end
            S_INVAL: begin
                if (icache_inval_ack) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                is_fi_nxt = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
                is_fi_nxt = 1'b0;
            end
        endcase
    end

    // State, FENCE.I flag and illegal pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            is_fi     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            is_fi     <= is_fi_nxt;
            illegal_q <= illegal_nxt;
        end
    end

    assign outstanding      = cnt;
    assign req_ready        = (state == S_IDLE);
    assign stall            = (state != S_IDLE);
    assign icache_inval_req = (state == S_INVAL);
    assign done             = (state == S_DONE);
    assign flush            = (state == S_DONE) && is_fi;
    assign illegal          = illegal_q;

endmodule

// File: tb/tb_fence_ctrl.sv
// tb_fence_ctrl: directed checks of fence_ctrl, default build plus
// a narrow-counter instance built without FENCE.I.
module tb_fence_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pred = '0;
    logic [3:0] succ = '0;

    logic       req_valid = 1'b0;
    logic [2:0] funct3 = '0;
    logic       mem_issue = 1'b0;
    logic       mem_done = 1'b0;
    logic       ack = 1'b0;
    logic       req_ready, stall, inval_req, flush, done, illegal;
    logic [3:0] outstanding;

    logic       req_valid1 = 1'b0;
    logic [2:0] funct3_1 = '0;
    logic       mem_issue1 = 1'b0;
    logic       mem_done1 = 1'b0;
    logic       req_ready1, stall1, inval_req1, flush1, done1, illegal1;
    logic [1:0] outstanding1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fence_ctrl u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .funct3(funct3), .pred(pred), .succ(succ),
        .mem_issue(mem_issue), .mem_done(mem_done),
        .outstanding(outstanding), .stall(stall),
        .icache_inval_req(inval_req), .icache_inval_ack(ack),
        .flush(flush), .done(done), .illegal(illegal)
    );

    fence_ctrl #(.OUTSTANDING_W(2), .HAS_ZIFENCEI(0)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .funct3(funct3_1), .pred(pred), .succ(succ),
        .mem_issue(mem_issue1), .mem_done(mem_done1),
        .outstanding(outstanding1), .stall(stall1),
        .icache_inval_req(inval_req1), .icache_inval_ack(1'b0),
        .flush(flush1), .done(done1), .illegal(illegal1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held low
        #22;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_inval", 32'(inval_req), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_cnt", 32'(outstanding), 32'd0);
        chk("rst_cnt1", 32'(outstanding1), 32'd0);
        rst = 1'b1;
        step();

        // FENCE with no traffic: DRAIN then DONE
        req_valid = 1'b1; funct3 = 3'b000; pred = 4'b0011; succ = 4'b0011;
        step();
        req_valid = 1'b0;
        chk("f0_c1_stall", 32'(stall), 32'd1);
        chk("f0_c1_ready", 32'(req_ready), 32'd0);
        chk("f0_c1_done", 32'(done), 32'd0);
        step();
        chk("f0_c2_done", 32'(done), 32'd1);
        chk("f0_c2_stall", 32'(stall), 32'd1);
        chk("f0_c2_flush", 32'(flush), 32'd0);
        step();
        chk("f0_c3_done", 32'(done), 32'd0);
        chk("f0_c3_stall", 32'(stall), 32'd0);
        chk("f0_c3_ready", 32'(req_ready), 32'd1);

        // No-op fence (pred=0): done on the next cycle
        req_valid = 1'b1; pred = 4'b0000; succ = 4'b1111;
        step();
        req_valid = 1'b0;
        chk("noop_done", 32'(done), 32'd1);
        step();
        chk("noop_ready", 32'(req_ready), 32'd1);

        // Three issues, then FENCE drained by three retires
        mem_issue = 1'b1;
        step(); step(); step();
        mem_issue = 1'b0;
        chk("f1_cnt3", 32'(outstanding), 32'd3);
        req_valid = 1'b1; funct3 = 3'b000; pred = 4'b1111; succ = 4'b1111;
        step();
        req_valid = 1'b0;
        chk("f1_drain_stall", 32'(stall), 32'd1);
        step();
        chk("f1_hold_done", 32'(done), 32'd0);
        mem_done = 1'b1;
        step();
        chk("f1_cnt2", 32'(outstanding), 32'd2);
        step();
        chk("f1_cnt1", 32'(outstanding), 32'd1);
        step();
        mem_done = 1'b0;
        chk("f1_cnt0", 32'(outstanding), 32'd0);
        chk("f1_cnt0_stall", 32'(stall), 32'd1);
        chk("f1_cnt0_done", 32'(done), 32'd0);
        step();
        chk("f1_done", 32'(done), 32'd1);
        chk("f1_flush", 32'(flush), 32'd0);
        step();
        chk("f1_idle_stall", 32'(stall), 32'd0);

        // FENCE.I with one outstanding op, ack after 5 cycles
        mem_issue = 1'b1;
        step();
        mem_issue = 1'b0;
        chk("fi_cnt1", 32'(outstanding), 32'd1);
        req_valid = 1'b1; funct3 = 3'b001;
        step();
        req_valid = 1'b0;
        mem_done = 1'b1;
        chk("fi_drain_inval", 32'(inval_req), 32'd0);
        step();
        mem_done = 1'b0;
        chk("fi_drained_inval", 32'(inval_req), 32'd0);
        chk("fi_drained_stall", 32'(stall), 32'd1);
        step();
        chk("fi_inval_rise", 32'(inval_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fi_inval_level", 32'(inval_req), 32'd1);
            chk("fi_inval_nodone", 32'(done), 32'd0);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("fi_done", 32'(done), 32'd1);
        chk("fi_flush", 32'(flush), 32'd1);
        chk("fi_inval_drop", 32'(inval_req), 32'd0);
        step();
        chk("fi_done_end", 32'(done), 32'd0);
        chk("fi_flush_end", 32'(flush), 32'd0);

        // Illegal funct3 sweep 010..111
        for (int f = 2; f < 8; f++) begin
            req_valid = 1'b1; funct3 = 3'(f);
            step();
            req_valid = 1'b0;
            chk("ill_pulse", 32'(illegal), 32'd1);
            chk("ill_stall", 32'(stall), 32'd0);
            chk("ill_done", 32'(done), 32'd0);
            chk("ill_ready", 32'(req_ready), 32'd1);
            step();
            chk("ill_clear", 32'(illegal), 32'd0);
        end

        // FENCE.I on the build without it is illegal
        req_valid1 = 1'b1; funct3_1 = 3'b001;
        step();
        req_valid1 = 1'b0;
        chk("nofi_illegal", 32'(illegal1), 32'd1);
        chk("nofi_stall", 32'(stall1), 32'd0);
        step();
        chk("nofi_clear", 32'(illegal1), 32'd0);

        // Narrow counter saturation, simultaneous, floor
        mem_issue1 = 1'b1;
        step(); step(); step(); step();
        chk("sat_cnt3", 32'(outstanding1), 32'd3);
        mem_done1 = 1'b1;
        step();
        chk("both_cnt3", 32'(outstanding1), 32'd3);
        mem_issue1 = 1'b0;
        step(); step(); step();
        chk("down_cnt0", 32'(outstanding1), 32'd0);
        step();
        mem_done1 = 1'b0;
        chk("floor_cnt0", 32'(outstanding1), 32'd0);

        // Simultaneous issue/done on default build, then issue during DRAIN
        mem_issue = 1'b1;
        step();
        mem_done = 1'b1;
        step();
        mem_issue = 1'b0; mem_done = 1'b0;
        chk("both_cnt1", 32'(outstanding), 32'd1);
        req_valid = 1'b1; funct3 = 3'b000; pred = 4'b1111; succ = 4'b1111;
        step();
        req_valid = 1'b0;
        mem_issue = 1'b1;
        step();
        mem_issue = 1'b0;
        mem_done = 1'b1;
        chk("ext_cnt2", 32'(outstanding), 32'd2);
        chk("ext_stall", 32'(stall), 32'd1);
        step(); step();
        mem_done = 1'b0;
        chk("ext_cnt0", 32'(outstanding), 32'd0);
        chk("ext_nodone", 32'(done), 32'd0);
        step();
        chk("ext_done", 32'(done), 32'd1);
        step();
        chk("ext_idle", 32'(stall), 32'd0);

        // Reset while in INVAL
        req_valid = 1'b1; funct3 = 3'b001;
        step();
        req_valid = 1'b0;
        step();
        chk("rinv_req", 32'(inval_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("rinv_req_drop", 32'(inval_req), 32'd0);
        chk("rinv_stall_drop", 32'(stall), 32'd0);
        chk("rinv_ready", 32'(req_ready), 32'd1);
        #1;
        rst = 1'b1;
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("stray_ack_done", 32'(done), 32'd0);
        chk("stray_ack_stall", 32'(stall), 32'd0);
        req_valid = 1'b1; funct3 = 3'b000;
        step();
        req_valid = 1'b0;
        chk("post_stall", 32'(stall), 32'd1);
        step();
        chk("post_done", 32'(done), 32'd1);
        chk("post_flush", 32'(flush), 32'd0);
        step();
        chk("post_idle", 32'(req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
